// File: rtl/fb_write_scheduler.sv
// fb_write_scheduler: arbitrates cursor stamps and clear sweeps onto the single frame-buffer write port
module fb_write_scheduler #(
   parameter int FB_W = 160,
   parameter int FB_H = 120,
   parameter int BOX_W = 10,
   parameter int BOX_H = 10,
   parameter int ADDR_W = 15,
   parameter logic [11:0] CLEAR_RGB = 12'h000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              paint_req,
   input  logic [9:0]        box_x,
   input  logic [9:0]        box_y,
   input  logic [11:0]       paint_rgb,
   input  logic              clear_req,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [11:0]       wr_data,
   output logic              busy,
   output logic              done
);
   typedef enum logic [1:0] {IDLE, PAINT, CLEAR} state_t;
   state_t state, state_n;
   logic [9:0] bx, by, bx_n, by_n, px, py, px_n, py_n;
   logic [11:0] rgb, rgb_n, prgb, prgb_n, wr_data_n;
   logic [10:0] cx, cy, cx_n, cy_n, x, y;
   logic [ADDR_W-1:0] ca, ca_n, wr_addr_n;
   logic pv, pv_n, cp, cp_n, fin, fin_n, wr_en_n, busy_n, in_fb, row_end, last_cell, last_addr;
   assign x = {1'b0, bx} + cx;
   assign y = {1'b0, by} + cy;
   assign in_fb = x < 11'(FB_W) && y < 11'(FB_H);
   assign row_end = cx == 11'(BOX_W - 1);
   assign last_cell = row_end && cy == 11'(BOX_H - 1);
   assign last_addr = ca == ADDR_W'(FB_W * FB_H - 1);
   // next-state, pending slots and next registered outputs
   always_comb begin
      state_n = state;
      bx_n = bx;
      by_n = by;
      rgb_n = rgb;
      px_n = paint_req ? box_x : px;
      py_n = paint_req ? box_y : py;
      prgb_n = paint_req ? paint_rgb : prgb;
      pv_n = pv | paint_req;
      cp_n = cp;
      cx_n = cx;
      cy_n = cy;
      ca_n = ca;
      fin_n = 1'b0;
      wr_en_n = 1'b0;
      wr_addr_n = wr_addr;
      wr_data_n = wr_data;
      case (state)
         IDLE: begin
            if (cp || clear_req) begin
               state_n = CLEAR;
               cp_n = 1'b0;
               ca_n = '0;
            end else if (pv_n) begin
               state_n = PAINT;
               bx_n = px_n;
               by_n = py_n;
               rgb_n = prgb_n;
               pv_n = 1'b0;
               cx_n = '0;
               cy_n = '0;
            end
         end
         PAINT: begin
            wr_en_n = in_fb;
            wr_addr_n = in_fb ? ADDR_W'(int'(y) * FB_W + int'(x)) : wr_addr;
            wr_data_n = in_fb ? rgb : wr_data;
            cx_n = row_end ? '0 : cx + 11'd1;
            cy_n = row_end ? cy + 11'd1 : cy;
            if (clear_req) begin
               state_n = CLEAR;
               ca_n = '0;
            end else if (last_cell) begin
               state_n = IDLE;
               fin_n = 1'b1;
            end
         end
         CLEAR: begin
            wr_en_n = 1'b1;
            wr_addr_n = ca;
            wr_data_n = CLEAR_RGB;
            ca_n = ca + 1'b1;
            cp_n = cp | clear_req;
            if (last_addr) begin
               state_n = IDLE;
               fin_n = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
      busy_n = state_n != IDLE;
   end
   // state, job context and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         bx <= '0;
         by <= '0;
         rgb <= '0;
         px <= '0;
         py <= '0;
         prgb <= '0;
         pv <= 1'b0;
         cp <= 1'b0;
         cx <= '0;
         cy <= '0;
         ca <= '0;
         fin <= 1'b0;
         wr_en <= 1'b0;
         wr_addr <= '0;
         wr_data <= '0;
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         state <= state_n;
         bx <= bx_n;
         by <= by_n;
         rgb <= rgb_n;
         px <= px_n;
         py <= py_n;
         prgb <= prgb_n;
         pv <= pv_n;
         cp <= cp_n;
         cx <= cx_n;
         cy <= cy_n;
         ca <= ca_n;
         fin <= fin_n;
         wr_en <= wr_en_n;
         wr_addr <= wr_addr_n;
         wr_data <= wr_data_n;
         busy <= busy_n;
         done <= fin;
      end
   end
endmodule

// File: tb/tb_fb_write_scheduler.sv
// tb_fb_write_scheduler: directed checks of stamp, clip, clear, arbitration and reset behaviour
module tb_fb_write_scheduler;
   logic clk = 1'b0, reset = 1'b1, paint_req = 1'b0, clear_req = 1'b0;
   logic [9:0] box_x = '0, box_y = '0;
   logic [11:0] paint_rgb = '0;
   logic wr_en, busy, done;
   logic [14:0] wr_addr;
   logic [11:0] wr_data;
   int total = 0, bad = 0;
   int n, nwr, fa, la, fw, lw, nd, dn, nb, nbad, fb_n, fb_a, a2, fw2;
   logic [11:0] exp_data;

   fb_write_scheduler dut (
      .clk(clk), .reset(reset), .paint_req(paint_req), .box_x(box_x), .box_y(box_y),
      .paint_rgb(paint_rgb), .clear_req(clear_req), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic clr();
      n = 0; nwr = 0; fa = -1; la = -1; fw = -1; lw = -1; nd = 0; dn = -1;
      nb = 0; nbad = 0; fb_n = -1; fb_a = -1; a2 = -1; fw2 = -1;
   endtask

   task automatic cyc();
      @(posedge clk);
      #2;
      n++;
      if (wr_en) begin
         if (nwr == 0) begin fa = int'(wr_addr); fw = n; end
         if (nd > 0 && a2 < 0) begin a2 = int'(wr_addr); fw2 = n; end
         la = int'(wr_addr);
         lw = n;
         nwr++;
         if (wr_data != exp_data) begin
            if (nbad == 0) begin fb_n = n; fb_a = int'(wr_addr); end
            nbad++;
         end
      end
      if (done) begin nd++; if (dn < 0) dn = n; end
      if (busy) nb++;
   endtask

   task automatic run(input int k);
      for (int i = 0; i < k; i++) cyc();
   endtask

   task automatic paint(input int bxv, input int byv, input logic [11:0] c);
      box_x = 10'(bxv); box_y = 10'(byv); paint_rgb = c; paint_req = 1'b1;
      cyc();
      paint_req = 1'b0;
   endtask

   task automatic clear();
      clear_req = 1'b1;
      cyc();
      clear_req = 1'b0;
   endtask

   initial begin
      clr();
      exp_data = 12'h000;
      run(3);
      chk("rst_wr_en", int'(wr_en), 0);
      chk("rst_addr", int'(wr_addr), 0);
      chk("rst_data", int'(wr_data), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      reset = 1'b0;
      run(2);

      clr(); exp_data = 12'hF00;
      paint(5, 7, 12'hF00);
      chk("t1_busy_rise", int'(busy), 1);
      run(110);
      chk("t1_nwr", nwr, 100);
      chk("t1_first", fa, 1125);
      chk("t1_last", la, 2574);
      chk("t1_latency", fw, 2);
      chk("t1_data", nbad, 0);
      chk("t1_done", nd, 1);
      chk("t1_done_at", dn, 102);
      chk("t1_busy", nb, 100);

      clr(); exp_data = 12'h0AB;
      paint(155, 115, 12'h0AB);
      run(110);
      chk("t2_nwr", nwr, 25);
      chk("t2_first", fa, 18555);
      chk("t2_last", la, 19199);
      chk("t2_data", nbad, 0);
      chk("t2_done_at", dn - fw, 100);
      chk("t2_done", nd, 1);

      clr(); exp_data = 12'h000;
      clear();
      run(19210);
      chk("t3_nwr", nwr, 19200);
      chk("t3_first", fa, 0);
      chk("t3_last", la, 19199);
      chk("t3_contig", lw - fw + 1, 19200);
      chk("t3_data", nbad, 0);
      chk("t3_done", nd, 1);
      chk("t3_done_at", dn, lw + 1);
      chk("t3_busy_end", int'(busy), 0);

      clr(); exp_data = 12'h0F0;
      paint(20, 30, 12'h0F0);
      while (n < 30) cyc();
      paint(50, 50, 12'h0F0);
      while (n < 40) cyc();
      paint(0, 0, 12'h0F0);
      run(250);
      chk("t4_done", nd, 2);
      chk("t4_nwr", nwr, 200);
      chk("t4_second_addr", a2, 0);
      chk("t4_gap", fw2, 103);
      chk("t4_last", la, 1449);

      clr(); exp_data = 12'h00F;
      paint(40, 40, 12'h00F);
      while (n < 50) cyc();
      clear();
      run(19300);
      chk("t5_paint_writes", nwr - nbad, 50);
      chk("t5_clear_start", fb_n, 52);
      chk("t5_clear_addr0", fb_a, 0);
      chk("t5_clear_writes", nbad, 19200);
      chk("t5_done", nd, 1);

      clr(); exp_data = 12'h000;
      clear();
      while (n < 100) cyc();
      paint(10, 10, 12'hABC);
      while (!(wr_en && wr_addr == 15'd8000) && n < 9000) cyc();
      chk("t6_reach8000", int'(wr_addr), 8000);
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      chk("t6_wr_en", int'(wr_en), 0);
      chk("t6_addr", int'(wr_addr), 0);
      chk("t6_data", int'(wr_data), 0);
      chk("t6_busy", int'(busy), 0);
      chk("t6_done0", int'(done), 0);
      clr();
      run(300);
      chk("t6_no_writes", nwr, 0);
      chk("t6_no_done", nd, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
